// File: rtl/arb_req_queue.sv
// ---------------------------------------------------------------------------
// arb_req_queue
//
// Request front-end for the 4-device TDM arbiter. Each device writes into its
// own FIFO. The request vector to the arbiter is taken from FIFO non-empty
// status. The arbiter's one-hot grant selects which head entry moves into a
// single registered valid/ready output slot feeding the shared resource.
//
// Parameters:
//   N      number of requesting devices (must match arbiter width)
//   DW     payload width per transaction
//   DEPTH  entries per device FIFO (power of 2, >= 2)
//
// Ports:
//   clk      clock
//   srst     synchronous reset, active-high
//   i_data   device payloads, device k at bits [k*DW +: DW]
//   i_valid  per-device push request
//   o_ready  per-device FIFO not full (forced low while srst is high)
//   o_req    per-device FIFO non-empty, to arbiter (forced low while srst)
//   i_grant  grant vector from arbiter, one-hot or zero
//   o_data   forwarded payload
//   o_src    index of the device that sourced o_data
//   o_valid  output slot holds a valid transaction
//   i_ready  downstream accepts o_data
//   o_err    sticky grant-protocol error
//
// Optional feature macro: ARB_REQ_GRANT_CHECK_EN
//   Defined   : a multi-hot effective grant (i_grant & o_req) blocks the pop
//               for that cycle and sets o_err until srst.
//   Undefined : no check; the lowest-index granted, non-empty device pops and
//               o_err is tied to 0.
// ---------------------------------------------------------------------------
module arb_req_queue #(
    parameter int N     = 4,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic [N*DW-1:0]      i_data,
    input  logic [N-1:0]         i_valid,
    output logic [N-1:0]         o_ready,
    output logic [N-1:0]         o_req,
    input  logic [N-1:0]         i_grant,
    output logic [DW-1:0]        o_data,
    output logic [$clog2(N)-1:0] o_src,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(N);

    logic [N-1:0]         push;
    logic [N-1:0]         pop;
    logic [N-1:0][DW-1:0] head;

    logic [N-1:0]         grant_hits;
    logic [SW-1:0]        pop_sel;
    logic                 pop_ok;
    logic                 out_free;

    logic [DW-1:0]        o_data_q;
    logic [SW-1:0]        o_src_q;
    logic                 o_valid_q;

    // -----------------------------------------------------------------------
    // Per-device FIFOs
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_fifo
        logic [DW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q, wr_ptr_d;
        logic [AW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;

        // Status comes only from registered count, so there is no path from
        // i_valid to o_req and the arbiter's grant loop stays single-cycle.
        assign o_ready[gi] = !srst && (count_q != CW'(DEPTH));
        assign o_req[gi]   = !srst && (count_q != '0);
        // Full FIFO blocks a push even if it is popped in the same cycle.
        assign push[gi]    = i_valid[gi] & o_ready[gi];
        // Head is read before any same-cycle write lands.
        assign head[gi]    = mem_q[rd_ptr_q];

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push[gi]) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop[gi]) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push[gi], pop[gi]})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (srst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage is not reset; pointers and count define what is live.
        always_ff @(posedge clk) begin
            if (push[gi]) begin
                mem_q[wr_ptr_q] <= i_data[gi*DW +: DW];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pop selection
    // -----------------------------------------------------------------------
    assign out_free   = !o_valid_q | i_ready;
    assign grant_hits = i_grant & o_req;

`ifdef ARB_REQ_GRANT_CHECK_EN
    logic multi_hot;
    logic err_q;

    // More than one bit set <=> clearing the lowest set bit leaves something.
    assign multi_hot = (grant_hits & (grant_hits - N'(1))) != '0;

    always_ff @(posedge clk) begin
        if (srst) begin
            err_q <= 1'b0;
        end else if (multi_hot) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    always_comb begin
        pop_sel = '0;
        // Descending scan so the lowest granted index wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (grant_hits[k]) begin
                pop_sel = SW'(k);
            end
        end
`ifdef ARB_REQ_GRANT_CHECK_EN
        pop_ok = (|grant_hits) & out_free & !multi_hot;
`else
        pop_ok = (|grant_hits) & out_free;
`endif
        pop = pop_ok ? (N'(1) << pop_sel) : '0;
    end

    // -----------------------------------------------------------------------
    // Output slot
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (srst) begin
            o_data_q  <= '0;
            o_src_q   <= '0;
            o_valid_q <= 1'b0;
        end else if (pop_ok) begin
            // Also covers accept-and-reload in one cycle.
            o_data_q  <= head[pop_sel];
            o_src_q   <= pop_sel;
            o_valid_q <= 1'b1;
        end else if (o_valid_q && i_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    assign o_data  = o_data_q;
    assign o_src   = o_src_q;
    assign o_valid = o_valid_q;

endmodule
